// File: rtl/alog_pipe.sv
// ---------------------------------------------------------------------------
// alog_pipe : pipelined base-2 antilog converter (LNS log domain -> linear).
//
// The input log word holds a signed characteristic k (upper IN_W-FRAC_W bits)
// and an unsigned fraction f (lower FRAC_W bits). The output is (1+f')*2^k as
// unsigned fixed point with OUT_INT integer bits. f' is either f itself
// (Mitchell approximation) or f minus a parabolic correction term.
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : input handshake, in_ready = ~out_valid | out_ready
//   in_data              : signed log2 magnitude {k, f}
//   in_sign              : LNS sign, passed through unchanged
//   in_zero              : LNS zero flag, forces a zero result
//   corr_en              : per-sample enable for the fraction correction
//   out_valid / out_ready: output handshake
//   out_data             : linear magnitude
//   out_sign             : registered in_sign
//   out_ovf              : result saturated to all-ones
//   out_unf              : nonzero result shifted completely out (reads 0)
//
// Three register stages; the whole pipe advances or holds as one unit.
// ---------------------------------------------------------------------------
module alog_pipe #(
    parameter int IN_W    = 19,
    parameter int FRAC_W  = 12,
    parameter int OUT_W   = 20,
    parameter int OUT_INT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sign,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int KW     = IN_W - FRAC_W;
    localparam int LSB_SH = OUT_W - OUT_INT;
    // Wide enough that LSB_SH + k never wraps, even for the extreme k values.
    localparam int IDX_W  = KW + $clog2(OUT_W + 1) + 2;
    localparam int SH_W   = $clog2(OUT_W);
    localparam int ALN_W  = OUT_W + FRAC_W;
    localparam int PW     = 2 * FRAC_W + 1;

    // p = f*(1-f) in fraction units, truncated; peaks at 2^(FRAC_W-2).
    function automatic logic [FRAC_W-1:0] mitchell_p(input logic [FRAC_W-1:0] f);
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW-1:0] prod;
        a    = PW'(f);
        b    = (PW'(1) << FRAC_W) - a;
        prod = a * b;
        return FRAC_W'(prod >> FRAC_W);
    endfunction

    // Correction of 5/16*p never exceeds f, so the subtraction cannot go negative.
    function automatic logic [FRAC_W-1:0] corr_frac(input logic [FRAC_W-1:0] f,
                                                    input logic [FRAC_W-1:0] p,
                                                    input logic              en);
        return en ? (f - ((p >> 2) + (p >> 4))) : f;
    endfunction

    // Places M's leading one at bit sh; bits below the output LSB are dropped.
    function automatic logic [OUT_W-1:0] align_m(input logic [FRAC_W:0] m,
                                                 input logic [SH_W-1:0] sh);
        logic [ALN_W-1:0] w;
        w = ALN_W'(m) << sh;
        return OUT_W'(w >> FRAC_W);
    endfunction

    logic w_adv;

    // Stage 1 registers
    logic                     r_vld_p1;
    logic signed [KW-1:0]     r_k_p1;
    logic [FRAC_W-1:0]        r_f_p1;
    logic [FRAC_W-1:0]        r_p_p1;
    logic                     r_sign_p1;
    logic                     r_zero_p1;
    logic                     r_corr_p1;

    // Stage 2 registers
    logic                     r_vld_p2;
    logic signed [KW-1:0]     r_k_p2;
    logic [FRAC_W:0]          r_m_p2;
    logic                     r_sign_p2;
    logic                     r_zero_p2;

    // Stage 3 registers (outputs)
    logic                     r_vld_p3;
    logic [OUT_W-1:0]         r_data_p3;
    logic                     r_sign_p3;
    logic                     r_ovf_p3;
    logic                     r_unf_p3;

    // Stage 3 combinational result
    logic signed [IDX_W-1:0]  w_idx;
    logic [OUT_W-1:0]         w_data;
    logic                     w_ovf;
    logic                     w_unf;

    assign w_adv    = ~r_vld_p3 | out_ready;
    assign in_ready = w_adv;

    // ---- stage 0 -> 1 : split word, form the correction product ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_k_p1    <= $signed(in_data[IN_W-1:FRAC_W]);
            r_f_p1    <= in_data[FRAC_W-1:0];
            r_p_p1    <= mitchell_p(in_data[FRAC_W-1:0]);
            r_sign_p1 <= in_sign;
            r_zero_p1 <= in_zero;
            r_corr_p1 <= corr_en;
        end
    end

    // ---- stage 1 -> 2 : corrected mantissa ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_k_p2    <= r_k_p1;
            r_m_p2    <= {1'b1, corr_frac(r_f_p1, r_p_p1, r_corr_p1)};
            r_sign_p2 <= r_sign_p1;
            r_zero_p2 <= r_zero_p1;
        end
    end

    // ---- stage 2 -> 3 : alignment, saturation and underflow ----
    always_comb begin
        w_idx  = $signed(IDX_W'(LSB_SH)) + IDX_W'(r_k_p2);
        w_data = '0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (r_zero_p2) begin
            w_data = '0;
        end else if (w_idx > $signed(IDX_W'(OUT_W - 1))) begin
            w_data = '1;
            w_ovf  = 1'b1;
        end else if (w_idx < $signed(IDX_W'(0))) begin
            w_unf  = 1'b1;
        end else begin
            w_data = align_m(r_m_p2, w_idx[SH_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_data_p3 <= '0;
            r_sign_p3 <= 1'b0;
            r_ovf_p3  <= 1'b0;
            r_unf_p3  <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1  <= in_valid;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_data_p3 <= w_data;
            r_sign_p3 <= r_sign_p2;
            r_ovf_p3  <= w_ovf;
            r_unf_p3  <= w_unf;
        end
    end

    assign out_valid = r_vld_p3;
    assign out_data  = r_data_p3;
    assign out_sign  = r_sign_p3;
    assign out_ovf   = r_ovf_p3;
    assign out_unf   = r_unf_p3;

endmodule

// File: tb/tb_alog_pipe.sv
module tb_alog_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [18:0] in_data = '0;
    logic        in_sign = 1'b0;
    logic        in_zero = 1'b0;
    logic        corr_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;
    logic        out_sign;
    logic        out_ovf;
    logic        out_unf;

    alog_pipe #(.IN_W(19), .FRAC_W(12), .OUT_W(20), .OUT_INT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sign(in_sign), .in_zero(in_zero), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sign(out_sign), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] data;
        logic        sign;
        logic        zero;
        logic        corr;
        logic [19:0] exp;
        logic        es;
        logic        eo;
        logic        eu;
    } vec_t;

    typedef struct {
        logic [19:0] exp;
        logic        es;
        logic        eo;
        logic        eu;
        int          cyc;
        bit          lat;
    } sb_t;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    vec_t cur;
    bit   cur_lat = 1'b0;

    logic        hold_vld = 1'b0;
    logic [22:0] hold_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent reference of the antilog for the default parameters.
    function automatic vec_t model(input logic [18:0] d, input logic s, input logic z, input logic c);
        vec_t v;
        int k, f, p, mf, m, idx;
        longint val;
        k   = int'($signed(d[18:12]));
        f   = int'(d[11:0]);
        p   = (f * (4096 - f)) / 4096;
        mf  = c ? f - (p / 4 + p / 16) : f;
        m   = 4096 + mf;
        idx = 19 + k;
        v.data = d; v.sign = s; v.zero = z; v.corr = c;
        v.es = s; v.eo = 1'b0; v.eu = 1'b0; v.exp = '0;
        if (z) begin
            v.exp = '0;
        end else if (idx > 19) begin
            v.exp = 20'hFFFFF; v.eo = 1'b1;
        end else if (idx < 0) begin
            v.eu = 1'b1;
        end else begin
            if (idx >= 12) val = longint'(m) << (idx - 12);
            else           val = longint'(m) >> (12 - idx);
            v.exp = val[19:0];
        end
        return v;
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_vld <= 1'b0;
        end else begin
            chk("in_ready_eq", {31'd0, in_ready}, {31'd0, (~out_valid | out_ready)});
            if (hold_vld) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold", {9'd0, out_data, out_sign, out_ovf, out_unf}, {9'd0, hold_val});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {12'd0, out_data}, 32'hDEAD);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("data", {12'd0, out_data}, {12'd0, e.exp});
                    chk("flags", {29'd0, out_sign, out_ovf, out_unf}, {29'd0, e.es, e.eo, e.eu});
                    if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
                end
            end
            hold_vld <= out_valid & ~out_ready;
            hold_val <= {out_data, out_sign, out_ovf, out_unf};
            if (in_valid && in_ready) begin
                sb_t n;
                n.exp = cur.exp; n.es = cur.es; n.eo = cur.eo; n.eu = cur.eu;
                n.cyc = cyc; n.lat = cur_lat;
                sb.push_back(n);
            end
        end
    end

    task automatic send(input vec_t v, input bit lat);
        int t;
        cur      = v;
        cur_lat  = lat;
        in_data  = v.data;
        in_sign  = v.sign;
        in_zero  = v.zero;
        corr_en  = v.corr;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic [18:0] d, input logic s, input logic z, input logic c,
                                input logic [19:0] e, input logic eo, input logic eu);
        vec_t v;
        v.data = d; v.sign = s; v.zero = z; v.corr = c;
        v.exp = e; v.es = s; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(19'h00800, 0, 0, 0, 20'hC0000, 0, 0);  // k=0 f=0.5
        tbl[1]  = mk(19'h7F800, 0, 0, 0, 20'h60000, 0, 0);  // k=-1
        tbl[2]  = mk(19'h6D000, 0, 0, 0, 20'h00001, 0, 0);  // k=-19 f=0
        tbl[3]  = mk(19'h6C000, 0, 0, 0, 20'h00000, 0, 1);  // k=-20
        tbl[4]  = mk(19'h01000, 0, 0, 0, 20'hFFFFF, 1, 0);  // k=+1
        tbl[5]  = mk(19'h01000, 0, 1, 0, 20'h00000, 0, 0);  // zero flag
        tbl[6]  = mk(19'h00800, 1, 0, 0, 20'hC0000, 0, 0);  // sign passthrough
        tbl[7]  = mk(19'h00800, 0, 0, 1, 20'hB6000, 0, 0);  // corrected f=0.5
        tbl[8]  = mk(19'h40000, 0, 0, 0, 20'h00000, 0, 1);  // k=-64
        tbl[9]  = mk(19'h3F000, 0, 0, 0, 20'hFFFFF, 1, 0);  // k=+63
        tbl[10] = mk(19'h74FFF, 0, 0, 0, 20'h000FF, 0, 0);  // k=-12, truncation
        tbl[11] = mk(19'h00000, 0, 0, 1, 20'h80000, 0, 0);  // corrected f=0

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {12'd0, out_data}, 32'd0);
        chk("rst_flags", {29'd0, out_sign, out_ovf, out_unf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single sample with latency check
        send(tbl[0], 1'b1);
        in_valid = 1'b0;
        drain();

        // Table, back-to-back
        for (int i = 0; i < 12; i++) send(tbl[i], 1'b0);
        in_valid = 1'b0;
        drain();

        // Random vectors against the model
        for (int i = 0; i < 40; i++) begin
            logic [18:0] d;
            logic [6:0]  kk;
            kk = 7'($signed(-22 + int'($urandom_range(0, 25))));
            d  = {kk, 12'($urandom_range(0, 4095))};
            send(model(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 1))), 1'b0);
        end
        in_valid = 1'b0;
        drain();

        // Stall: 8 back-to-back, out_ready low for cycles 4..9
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(model({7'h7F - 7'(i), 12'(i * 500)}, 1'(i), 1'b0, 1'(i >> 1)), 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with samples in flight
        for (int i = 0; i < 3; i++) send(tbl[1], 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data", {12'd0, out_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        send(tbl[7], 1'b1);
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
